// File: rtl/l1cache_pkg.sv
// Shared types for the framebuffer L1: word/address types, L1 geometry and FSM states.
// attrs: fb_addr_t, fb_word_t. cache_attrs: depth, index/tag split, helpers.
package attrs;
  typedef logic [15:0] fb_addr_t;
  typedef logic [15:0] fb_word_t;
endpackage

package cache_attrs;
  import attrs::*;

  localparam int L1_DEPTH = 256;
  localparam int L1ADDRIDX_LO = 0;
  localparam int L1ADDRIDX_HI = $clog2(L1_DEPTH) - 1;
  localparam int L1ADDRTAG_LO = L1ADDRIDX_HI + 1;
  localparam int L1ADDRTAG_HI = $bits(fb_addr_t) - 1;

  typedef logic [L1ADDRIDX_HI:L1ADDRIDX_LO] l1_idx_t;
  typedef logic [L1ADDRTAG_HI:L1ADDRTAG_LO] l1_tag_t;

  typedef enum logic [2:0] {
    s_idle,
    s_lookup,
    s_fill,
    s_write,
    s_done
  } l1_state_t;

  function automatic l1_idx_t idx_of(input fb_addr_t a);
    return a[L1ADDRIDX_HI:L1ADDRIDX_LO];
  endfunction

  function automatic l1_tag_t tag_of(input fb_addr_t a);
    return a[L1ADDRTAG_HI:L1ADDRTAG_LO];
  endfunction
endpackage

// File: rtl/l1cache_if.sv
// Bus bundles around the L1: core side (core is master) and L2 side
// (L1 is master of requests, responder to the invalidate broadcast).
interface l1_core_if;
  import attrs::*;
  logic     core_en;
  logic     core_w;
  fb_addr_t core_addr;
  fb_word_t core_in;
  fb_word_t core_out;
  logic     core_ready;

  modport master (
    output core_en, core_w, core_addr, core_in,
    input  core_out, core_ready
  );
  modport slave (
    input  core_en, core_w, core_addr, core_in,
    output core_out, core_ready
  );
endinterface

interface l1_l2_if;
  import attrs::*;
  logic     l2_en;
  logic     l2_w;
  fb_addr_t l2_addr;
  fb_word_t l2_in;
  fb_word_t l2_out;
  logic     l2_ready;
  logic     invalidate;
  fb_addr_t inv_addr;
  logic     invalidated;

  modport master (
    output l2_en, l2_w, l2_addr, l2_in, invalidated,
    input  l2_out, l2_ready, invalidate, inv_addr
  );
  modport slave (
    input  l2_en, l2_w, l2_addr, l2_in, invalidated,
    output l2_out, l2_ready, invalidate, inv_addr
  );
endinterface

// File: rtl/l1cache_sp_bram.sv
// Single-port RAM with registered read; holds the L1 data words.
// Ports: clk, we_i, addr_i, wdata_i, rdata_o (valid the cycle after addr_i).
module sp_bram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/l1cache.sv
// Direct-mapped write-around L1: read hits served locally, misses and writes to L2.
// Ports: clk, rst (sync, active-high), core (l1_core_if.slave), l2 (l1_l2_if.master).
module l1cache
  import attrs::*;
  import cache_attrs::*;
#(
  parameter int L1_DEPTH = cache_attrs::L1_DEPTH
) (
  input logic        clk,
  input logic        rst,
  l1_core_if.slave   core,
  l1_l2_if.master    l2
);
  l1_state_t state_q, state_d;
  fb_addr_t  addr_q;
  fb_word_t  data_q;
  logic      inv_ack_q;

  logic [L1_DEPTH-1:0] valid_q;
  l1_tag_t             tag_q [L1_DEPTH];

  l1_idx_t  cidx, ridx, iidx, bidx;
  l1_tag_t  ctag, rtag, itag;
  fb_word_t rdata;
  logic     accept, hit, core_hit, fill_we, inv_hit;

  assign cidx = idx_of(core.core_addr);
  assign ctag = tag_of(core.core_addr);
  assign ridx = idx_of(addr_q);
  assign rtag = tag_of(addr_q);
  assign iidx = idx_of(l2.inv_addr);
  assign itag = tag_of(l2.inv_addr);

  assign accept   = (state_q == s_idle) && core.core_en;
  assign hit      = valid_q[ridx] && (tag_q[ridx] == rtag);
  assign core_hit = valid_q[cidx] && (tag_q[cidx] == ctag);
  assign fill_we  = (state_q == s_fill) && l2.l2_ready && !rst;

  // When a fill lands on the invalidated index, match against the
  // incoming tag, since that is what the line holds afterwards.
  always_comb begin
    inv_hit = 1'b0;
    if (l2.invalidate) begin
      if (fill_we && (iidx == ridx)) inv_hit = (itag == rtag);
      else inv_hit = valid_q[iidx] && (tag_q[iidx] == itag);
    end
  end

  // Read is issued from idle so the word is ready in lookup.
  assign bidx = (state_q == s_idle) ? cidx : ridx;

  sp_bram #(
    .WIDTH ($bits(fb_word_t)),
    .DEPTH (L1_DEPTH)
  ) u_data (
    .clk     (clk),
    .we_i    (fill_we),
    .addr_i  (bidx),
    .wdata_i (l2.l2_out),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (fill_we) valid_q[ridx] <= 1'b1;
      if (accept && core.core_w && core_hit) valid_q[cidx] <= 1'b0;
      if (inv_hit) valid_q[iidx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) tag_q[ridx] <= rtag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      data_q    <= '0;
      inv_ack_q <= 1'b0;
    end else begin
      inv_ack_q <= l2.invalidate;
      if (accept) begin
        addr_q <= core.core_addr;
        data_q <= core.core_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= s_idle;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      s_idle: begin
        if (core.core_en) state_d = core.core_w ? s_write : s_lookup;
      end
      s_lookup: state_d = hit ? s_done : s_fill;
      s_fill:   if (l2.l2_ready) state_d = s_done;
      s_write:  if (l2.l2_ready) state_d = s_done;
      s_done:   state_d = s_idle;
      default:  state_d = s_idle;
    endcase
  end

  logic     rdy, en, w;
  fb_word_t cout, lin;
  fb_addr_t laddr;

  always_comb begin
    rdy   = 1'b0;
    cout  = '0;
    en    = 1'b0;
    w     = 1'b0;
    laddr = '0;
    lin   = '0;
    unique case (state_q)
      s_lookup: begin
        if (hit) begin
          rdy  = 1'b1;
          cout = rdata;
        end
      end
      s_fill: begin
        en    = 1'b1;
        laddr = addr_q;
        if (l2.l2_ready) begin
          rdy  = 1'b1;
          cout = l2.l2_out;
        end
      end
      s_write: begin
        en    = 1'b1;
        w     = 1'b1;
        laddr = addr_q;
        lin   = data_q;
        rdy   = l2.l2_ready;
      end
      default: ;
    endcase
    if (rst) begin
      rdy   = 1'b0;
      cout  = '0;
      en    = 1'b0;
      w     = 1'b0;
      laddr = '0;
      lin   = '0;
    end
  end

  assign core.core_ready = rdy;
  assign core.core_out   = cout;
  assign l2.l2_en        = en;
  assign l2.l2_w         = w;
  assign l2.l2_addr      = laddr;
  assign l2.l2_in        = lin;
  assign l2.invalidated  = inv_ack_q && !rst;
endmodule

// File: tb/tb_l1cache.sv
// Directed bench for l1cache: fills, hits, write-around, invalidates, reset mid-miss.
// Acts as core and as the L2 slot; prints one summary line.
module tb_l1cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;
  bit   ipend = 1'b0;
  bit   ackc = 1'b0;

  always #5 clk = ~clk;

  l1_core_if cif ();
  l1_l2_if   lif ();

  l1cache #(.L1_DEPTH(256)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (cif.slave),
    .l2   (lif.master)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic inv_pre(input int i, input int at,
                         input logic [15:0] ia);
    ackc = ipend;
    if (ipend) begin
      lif.invalidate = 1'b0;
      ipend = 1'b0;
    end
    if (i == at) begin
      lif.invalidate = 1'b1;
      lif.inv_addr = ia;
      ipend = 1'b1;
    end
  endtask

  task automatic inv_post();
    if (ackc) chk("inv_ack", lif.invalidated, 1);
  endtask

  task automatic rd(input logic [15:0] a, input bit hit,
                    input int lat, input logic [15:0] d,
                    input int at, input logic [15:0] ia);
    int nen;
    nen = 0;
    @(negedge clk);
    cif.core_en = 1'b1;
    cif.core_w = 1'b0;
    cif.core_addr = a;
    @(negedge clk);
    #1;
    chk("look_l2en", lif.l2_en, 0);
    if (hit) begin
      chk("hit_rdy", cif.core_ready, 1);
      chk("hit_data", cif.core_out, d);
      @(negedge clk);
      cif.core_en = 1'b0;
      #1;
      chk("hdone_l2en", lif.l2_en, 0);
      chk("hdone_rdy", cif.core_ready, 0);
    end else begin
      chk("miss_rdy", cif.core_ready, 0);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        inv_pre(i, at, ia);
        if (i == lat - 1) begin
          lif.l2_ready = 1'b1;
          lif.l2_out = d;
        end
        #1;
        inv_post();
        if (lif.l2_en) nen++;
        chk("fill_addr", lif.l2_addr, a);
        chk("fill_w", lif.l2_w, 0);
        chk("fill_rdy", cif.core_ready, i == lat - 1);
        if (i == lat - 1) chk("fill_data", cif.core_out, d);
      end
      @(negedge clk);
      inv_pre(lat, at, ia);
      lif.l2_ready = 1'b0;
      cif.core_en = 1'b0;
      #1;
      inv_post();
      chk("fill_en_cyc", nen, lat);
      chk("fdone_l2en", lif.l2_en, 0);
      chk("fdone_rdy", cif.core_ready, 0);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d,
                    input int lat, input int at,
                    input logic [15:0] ia);
    @(negedge clk);
    cif.core_en = 1'b1;
    cif.core_w = 1'b1;
    cif.core_addr = a;
    cif.core_in = d;
    #1;
    chk("wacc_l2en", lif.l2_en, 0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      inv_pre(i, at, ia);
      if (i == lat - 1) lif.l2_ready = 1'b1;
      #1;
      inv_post();
      chk("wr_l2en", lif.l2_en, 1);
      chk("wr_l2w", lif.l2_w, 1);
      chk("wr_addr", lif.l2_addr, a);
      chk("wr_data", lif.l2_in, d);
      chk("wr_rdy", cif.core_ready, i == lat - 1);
    end
    @(negedge clk);
    inv_pre(lat, at, ia);
    lif.l2_ready = 1'b0;
    cif.core_en = 1'b0;
    #1;
    inv_post();
    chk("wdone_l2en", lif.l2_en, 0);
    chk("wdone_rdy", cif.core_ready, 0);
  endtask

  task automatic inv_op(input logic [15:0] a);
    @(negedge clk);
    lif.invalidate = 1'b1;
    lif.inv_addr = a;
    #1;
    chk("inv_early", lif.invalidated, 0);
    @(negedge clk);
    lif.invalidate = 1'b0;
    #1;
    chk("inv_pulse", lif.invalidated, 1);
    @(negedge clk);
    #1;
    chk("inv_end", lif.invalidated, 0);
  endtask

  task automatic rst_mid_miss(input logic [15:0] a);
    @(negedge clk);
    cif.core_en = 1'b1;
    cif.core_w = 1'b0;
    cif.core_addr = a;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rm_l2en_pre", lif.l2_en, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rm_l2en", lif.l2_en, 0);
    chk("rm_l2addr", lif.l2_addr, 0);
    chk("rm_rdy", cif.core_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    cif.core_en = 1'b0;
    @(negedge clk);
    lif.l2_ready = 1'b1;
    lif.l2_out = 16'hDEAD;
    #1;
    chk("rm_stray_rdy", cif.core_ready, 0);
    chk("rm_stray_en", lif.l2_en, 0);
    @(negedge clk);
    lif.l2_ready = 1'b0;
  endtask

  initial begin
    cif.core_en = 1'b0;
    cif.core_w = 1'b0;
    cif.core_addr = '0;
    cif.core_in = '0;
    lif.l2_out = '0;
    lif.l2_ready = 1'b0;
    lif.invalidate = 1'b1;
    lif.inv_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy", cif.core_ready, 0);
    chk("rst_out", cif.core_out, 0);
    chk("rst_l2en", lif.l2_en, 0);
    chk("rst_l2w", lif.l2_w, 0);
    chk("rst_l2addr", lif.l2_addr, 0);
    chk("rst_l2in", lif.l2_in, 0);
    chk("rst_invd", lif.invalidated, 0);
    @(negedge clk);
    lif.invalidate = 1'b0;
    rst = 1'b0;

    rd(16'h0100, 0, 3, 16'hABCD, -1, 16'h0);
    rd(16'h0100, 1, 0, 16'hABCD, -1, 16'h0);
    wr(16'h0100, 16'h1234, 2, -1, 16'h0);
    rd(16'h0100, 0, 1, 16'h1234, -1, 16'h0);
    rd(16'h0100, 1, 0, 16'h1234, -1, 16'h0);
    inv_op(16'h0100);
    rd(16'h0100, 0, 2, 16'h1234, -1, 16'h0);
    inv_op(16'h0200);
    rd(16'h0100, 1, 0, 16'h1234, -1, 16'h0);
    rd(16'h0305, 0, 4, 16'h5555, 1, 16'h0100);
    rd(16'h0100, 0, 1, 16'h1234, -1, 16'h0);
    rd(16'h0305, 1, 0, 16'h5555, -1, 16'h0);
    wr(16'h0100, 16'h7777, 3, 0, 16'h0100);
    rd(16'h0410, 0, 2, 16'h9999, 1, 16'h0410);
    rd(16'h0410, 0, 1, 16'h9999, -1, 16'h0);
    rd(16'h0410, 1, 0, 16'h9999, -1, 16'h0);
    rd(16'h0100, 0, 1, 16'h4242, -1, 16'h0);
    rd(16'h0100, 1, 0, 16'h4242, -1, 16'h0);
    rst_mid_miss(16'h0520);
    rd(16'h0100, 0, 2, 16'h4242, -1, 16'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
